// File: rtl/spi_periph_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
// Holds the FSM encoding, the R/W bit values and the frame-length function.
package spi_periph_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin.
// Provides the synchronised level and single-cycle rise/fall pulses.
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stages <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], pin};
        end
    end

    // Edges compare the two oldest stages; the newer of the pair is stages[SYNC_STAGES-2].
    assign level = stages[SYNC_STAGES-1];
    assign rise  = stages[SYNC_STAGES-2] & ~stages[SYNC_STAGES-1];
    assign fall  = ~stages[SYNC_STAGES-2] & stages[SYNC_STAGES-1];

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral exposing a bank of control registers.
// Frame is R/W bit, address, data (MSB first); reads shift the addressed register out on CIPO.
module spi_regfile_peripheral
    import spi_periph_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       SCLK,
    input  logic                       COPI,
    input  logic                       nCS,
    output logic                       CIPO,
    output logic                       CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       frame_err
);

    localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
    localparam int ADDR_END  = 1 + ADDR_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic copi_level, copi_rise, copi_fall;
    logic ncs_level, ncs_rise, ncs_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .pin(SCLK),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .pin(COPI),
        .level(copi_level), .rise(copi_rise), .fall(copi_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .pin(nCS),
        .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_level, copi_rise, copi_fall, ncs_level};

    state_t                state, state_d;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_LEN-1:0]  rx_shift;
    logic [DATA_W-1:0]     tx_shift;
    logic [ADDR_W-1:0]     addr;
    logic                  rw;
    logic                  cipo_oe_r;
    logic [DATA_W-1:0]     regs [NUM_REGS];

    logic                  start_frame, abort_frame, latch_addr, end_frame;
    logic                  full_cnt, sample_bit, shift_tx;
    logic [ADDR_W-1:0]     addr_field;
    logic                  rw_field;
    logic [DATA_W-1:0]     rd_word;

    assign addr_field = rx_shift[ADDR_W-1:0];
    assign rw_field   = rx_shift[ADDR_W];
    assign full_cnt   = (bit_cnt == CNT_W'(FRAME_LEN));
    assign sample_bit = (state inside {ST_CMD, ST_DATA}) && sclk_rise && !full_cnt && !ncs_rise;
    // The fall right after the last address bit must not shift, or the MSB would never be seen.
    assign shift_tx   = (state == ST_DATA) && (rw == RW_READ) && sclk_fall
                        && (bit_cnt > CNT_W'(ADDR_END));

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(addr_field) == i) rd_word = regs[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d     = state;
        start_frame = 1'b0;
        abort_frame = 1'b0;
        latch_addr  = 1'b0;
        end_frame   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_d     = ST_CMD;
                    start_frame = 1'b1;
                end
            end
            ST_CMD: begin
                if (ncs_rise) begin
                    state_d     = ST_IDLE;
                    abort_frame = 1'b1;
                end else if (bit_cnt == CNT_W'(ADDR_END)) begin
                    state_d    = ST_DATA;
                    latch_addr = 1'b1;
                end
            end
            ST_DATA: begin
                if (ncs_rise) begin
                    state_d     = ST_IDLE;
                    abort_frame = 1'b1;
                end else if (full_cnt) begin
                    state_d   = ST_DONE;
                    end_frame = 1'b1;
                end
            end
            ST_DONE: begin
                if (ncs_rise) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            addr      <= '0;
            rw        <= RW_READ;
            cipo_oe_r <= 1'b0;
            wr_strobe <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= '0;
            frame_err <= abort_frame;

            if (start_frame) begin
                bit_cnt   <= '0;
                rx_shift  <= '0;
                tx_shift  <= '0;
                addr      <= '0;
                rw        <= RW_READ;
                cipo_oe_r <= 1'b0;
            end else if (sample_bit) begin
                bit_cnt  <= bit_cnt + 1'b1;
                rx_shift <= {rx_shift[FRAME_LEN-2:0], copi_level};
            end

            if (latch_addr) begin
                addr <= addr_field;
                rw   <= rw_field;
                if (rw_field == RW_READ) begin
                    tx_shift  <= rd_word;
                    cipo_oe_r <= 1'b1;
                end
            end else if (shift_tx) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            // Whole-word update from the finished frame; out-of-range addresses match nothing.
            if (end_frame) begin
                tx_shift <= '0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (rw == RW_WRITE && int'(addr) == i) begin
                        regs[i]      <= rx_shift[DATA_W-1:0];
                        wr_strobe[i] <= 1'b1;
                    end
                end
            end

            if (abort_frame || (state == ST_DONE && ncs_rise)) cipo_oe_r <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DATA_W +: DATA_W] = regs[g];
    end

    assign CIPO    = cipo_oe_r & tx_shift[DATA_W-1];
    assign CIPO_oe = cipo_oe_r;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench for spi_regfile_peripheral: a default build (8-bit data, 7-bit address, 5 regs)
// and a wide build (16-bit data, 4-bit address, 16 regs) sharing SCLK/COPI with separate chip selects.
module tb_spi_regfile_peripheral;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sclk = 1'b0;
    logic copi = 1'b0;
    logic ncs_a = 1'b1;
    logic ncs_b = 1'b1;

    logic         cipo_a, cipo_oe_a, frame_err_a;
    logic [39:0]  reg_q_a;
    logic [4:0]   wr_strobe_a;
    logic         cipo_b, cipo_oe_b, frame_err_b;
    logic [255:0] reg_q_b;
    logic [15:0]  wr_strobe_b;

    always #5 clk = ~clk;

    spi_regfile_peripheral #(.DATA_W(8), .ADDR_W(7), .NUM_REGS(5), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .SCLK(sclk), .COPI(copi), .nCS(ncs_a),
        .CIPO(cipo_a), .CIPO_oe(cipo_oe_a), .reg_q(reg_q_a),
        .wr_strobe(wr_strobe_a), .frame_err(frame_err_a)
    );

    spi_regfile_peripheral #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(16), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .SCLK(sclk), .COPI(copi), .nCS(ncs_b),
        .CIPO(cipo_b), .CIPO_oe(cipo_oe_b), .reg_q(reg_q_b),
        .wr_strobe(wr_strobe_b), .frame_err(frame_err_b)
    );

    typedef struct {
        int          dut;
        int          kind;   // 0 = write, 1 = read
        int          idx;
        logic [15:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  model_a [5];
    logic [15:0] model_b [16];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          err_a    = 0;
    int          err_b    = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] pack_a();
        logic [39:0] r;
        for (int i = 0; i < 5; i++) r[i*8 +: 8] = model_a[i];
        return r;
    endfunction

    function automatic logic [255:0] pack_b();
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = model_b[i];
        return r;
    endfunction

    task automatic sb_write(input int dut);
        exp_t        e;
        logic [15:0] strobe;
        strobe = (dut == 0) ? {11'd0, wr_strobe_a} : wr_strobe_b;
        if (sb_q.size() == 0 || sb_q[0].kind != 0 || sb_q[0].dut != dut) begin
            check_eq($sformatf("unexpected_strobe_dut%0d", dut), 256'(strobe), 256'(0));
        end else begin
            e = sb_q.pop_front();
            check_eq($sformatf("strobe_dut%0d_a%0d", dut, e.idx), 256'(strobe), 256'(1) << e.idx);
            if (dut == 0) begin
                model_a[e.idx] = e.val[7:0];
                check_eq("reg_q_a_after_write", 256'(reg_q_a), 256'(pack_a()));
            end else begin
                model_b[e.idx] = e.val;
                check_eq("reg_q_b_after_write", reg_q_b, pack_b());
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (frame_err_a) err_a++;
            if (frame_err_b) err_b++;
            if (wr_strobe_a != '0) sb_write(0);
            if (wr_strobe_b != '0) sb_write(1);
        end
    end

    // Drives nbits of a len-bit frame, MSB first; CIPO is sampled just before each SCLK rise.
    task automatic spi_frame(input int dut, input int len, input int nbits, input logic [31:0] bits,
                             input bit end_cs, output logic [31:0] rx, output logic oe_last);
        rx      = '0;
        oe_last = 1'b0;
        if (dut == 0) ncs_a = 1'b0;
        else          ncs_b = 1'b0;
        #80;
        for (int i = 0; i < nbits; i++) begin
            copi = bits[len-1-i];
            #80;
            rx = {rx[30:0], (dut == 0) ? cipo_a : cipo_b};
            if (i == len - 1) oe_last = (dut == 0) ? cipo_oe_a : cipo_oe_b;
            sclk = 1'b1;
            #80;
            sclk = 1'b0;
        end
        copi = 1'b0;
        #80;
        if (end_cs) begin
            ncs_a = 1'b1;
            ncs_b = 1'b1;
            #200;
        end
    endtask

    function automatic logic [31:0] build(input int dut, input logic rw, input int addr, input logic [15:0] d);
        if (dut == 0) return {16'd0, rw, 7'(addr), d[7:0]};
        return {11'd0, rw, 4'(addr), d};
    endfunction

    task automatic wr(input int dut, input int addr, input logic [15:0] d);
        logic [31:0] rx;
        logic        oe;
        int          len;
        bit          in_range;
        len      = (dut == 0) ? 16 : 21;
        in_range = (dut == 0) ? (addr < 5) : (addr < 16);
        if (in_range) sb_q.push_back('{dut: dut, kind: 0, idx: addr, val: d});
        spi_frame(dut, len, len, build(dut, 1'b1, addr, d), 1'b1, rx, oe);
        check_eq($sformatf("wr_dut%0d_a%0d_strobed", dut, addr), 256'(sb_q.size()), 256'(0));
        sb_q.delete();
        check_eq($sformatf("wr_dut%0d_cipo_oe", dut), 256'(oe), 256'(0));
        if (dut == 0) check_eq("reg_q_a_after_frame", 256'(reg_q_a), 256'(pack_a()));
        else          check_eq("reg_q_b_after_frame", reg_q_b, pack_b());
    endtask

    task automatic rd(input int dut, input int addr);
        logic [31:0] rx;
        logic        oe;
        logic [15:0] exp;
        exp_t        e;
        int          len;
        len = (dut == 0) ? 16 : 21;
        if (dut == 0) exp = (addr < 5) ? {8'd0, model_a[addr]} : 16'd0;
        else          exp = (addr < 16) ? model_b[addr] : 16'd0;
        sb_q.push_back('{dut: dut, kind: 1, idx: addr, val: exp});
        spi_frame(dut, len, len, build(dut, 1'b0, addr, 16'd0), 1'b1, rx, oe);
        e = sb_q.pop_front();
        if (dut == 0) check_eq($sformatf("rd_dut0_a%0d_data", addr), 256'(rx[7:0]), 256'(e.val[7:0]));
        else          check_eq($sformatf("rd_dut1_a%0d_data", addr), 256'(rx[15:0]), 256'(e.val));
        check_eq($sformatf("rd_dut%0d_cipo_oe_during", dut), 256'(oe), 256'(1));
        check_eq($sformatf("rd_dut%0d_cipo_oe_after", dut),
                 256'((dut == 0) ? cipo_oe_a : cipo_oe_b), 256'(0));
        check_eq($sformatf("rd_dut%0d_cipo_after", dut), 256'((dut == 0) ? cipo_a : cipo_b), 256'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rx;
        logic        oe;
        int          err_before;

        for (int i = 0; i < 5; i++)  model_a[i] = '0;
        for (int i = 0; i < 16; i++) model_b[i] = '0;

        #33;
        check_eq("rst_reg_q_a", 256'(reg_q_a), 256'(0));
        check_eq("rst_reg_q_b", reg_q_b, 256'(0));
        check_eq("rst_wr_strobe_a", 256'(wr_strobe_a), 256'(0));
        check_eq("rst_frame_err_a", 256'(frame_err_a), 256'(0));
        check_eq("rst_cipo_a", 256'(cipo_a), 256'(0));
        check_eq("rst_cipo_oe_a", 256'(cipo_oe_a), 256'(0));
        @(negedge clk);
        rst = 1'b1;
        #100;

        // Basic write, then write/read-back of several patterns.
        wr(0, 0, 16'h00A5);
        wr(0, 3, 16'h005A);
        rd(0, 3);
        wr(0, 1, 16'h0081);
        wr(0, 4, 16'h00FF);
        rd(0, 1);
        rd(0, 4);
        rd(0, 0);

        // Out-of-range addresses: writes dropped, reads return zero.
        wr(0, 9, 16'h003C);
        wr(0, 127, 16'h0055);
        rd(0, 9);
        rd(0, 5);

        // Short frame: 12 of 16 bits.
        err_before = err_a;
        spi_frame(0, 16, 12, build(0, 1'b1, 2, 16'h00FF), 1'b1, rx, oe);
        check_eq("abort_frame_err_pulses", 256'(err_a - err_before), 256'(1));
        check_eq("abort_reg_q_a", 256'(reg_q_a), 256'(pack_a()));
        wr(0, 2, 16'h0011);
        rd(0, 2);

        // Reset in the middle of a data phase.
        err_before = err_a;
        spi_frame(0, 16, 12, build(0, 1'b1, 4, 16'h0077), 1'b0, rx, oe);
        rst   = 1'b0;
        ncs_a = 1'b1;
        #100;
        for (int i = 0; i < 5; i++)  model_a[i] = '0;
        for (int i = 0; i < 16; i++) model_b[i] = '0;
        check_eq("midframe_rst_reg_q_a", 256'(reg_q_a), 256'(0));
        check_eq("midframe_rst_cipo_oe_a", 256'(cipo_oe_a), 256'(0));
        @(negedge clk);
        rst = 1'b1;
        #100;
        wr(0, 1, 16'h00C3);
        rd(0, 1);
        rd(0, 3);
        check_eq("rst_no_frame_err", 256'(err_a - err_before), 256'(0));

        // Wide build: fill and read back all 16 registers.
        for (int i = 0; i < 16; i++) wr(1, i, 16'(i * 16'h1357) ^ 16'hA5C3);
        for (int i = 0; i < 16; i++) rd(1, i);

        #200;
        check_eq("final_reg_q_a", 256'(reg_q_a), 256'(pack_a()));
        check_eq("final_reg_q_b", reg_q_b, pack_b());
        check_eq("final_frame_err_a_total", 256'(err_a), 256'(1));
        check_eq("final_frame_err_b_total", 256'(err_b), 256'(0));
        check_eq("final_scoreboard_empty", 256'(sb_q.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
